mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the RAM macro.
// The slave side is the arbiter; the master side is the requesters plus the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous RAM between CPU (port 0)
// and DMA (port 1). IDLE -> ACCESS -> WAIT, ack pulses in the following IDLE cycle.

// Per-requester return path: one-cycle ack and the read-data holding register.
module mem_arbiter_port #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic              rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (reset) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= done;
            if (done && rd)
                rdata <= mem_rdata;
        end
    end
endmodule

module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t state, state_nx;

    req_t [NUM_PORTS-1:0]              rq;
    req_t                              cur;
    logic [NUM_PORTS-1:0]              req, ack, elig, done;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_v;
    logic                              grant, win;
    logic                              owner_q, last_owner;

    assign rq[0] = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
    assign rq[1] = {bus.dma_we, bus.dma_addr, bus.dma_wdata};
    assign req   = {bus.dma_req, bus.cpu_req};

    // A port being acked this cycle still shows its old req; mask it so it re-arbitrates next cycle.
    assign elig  = req & ~ack;
    assign grant = |elig;
    assign win   = (&elig) ? ~last_owner : elig[1];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (grant) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_WAIT;
            S_WAIT:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // last_owner resets to DMA so the first tie goes to the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= '0;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
        end else if (state == S_IDLE && grant) begin
            cur        <= rq[win];
            owner_q    <= win;
            last_owner <= win;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign done[i] = (state == S_WAIT) && (owner_q == 1'(i));
        mem_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .clk       (clk),
            .reset     (reset),
            .done      (done[i]),
            .rd        (~cur.we),
            .mem_rdata (bus.mem_rdata),
            .ack       (ack[i]),
            .rdata     (rdata_v[i])
        );
    end

    assign bus.cpu_ack   = ack[0];
    assign bus.dma_ack   = ack[1];
    assign bus.cpu_rdata = rdata_v[0];
    assign bus.dma_rdata = rdata_v[1];

    // Strobes decode straight from the state register, so they can only be high in ACCESS.
    assign bus.mem_addr  = cur.addr;
    assign bus.mem_wdata = cur.wdata;
    assign bus.mem_we    = (state == S_ACCESS) &&  cur.we;
    assign bus.mem_re    = (state == S_ACCESS) && !cur.we;
    assign bus.busy      = (state != S_IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, hand sequences, and a random
// run checked against a transaction-level timeline model.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // RAM macro: synchronous write, synchronous read
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return {2'b00, bus.cpu_ack, bus.dma_ack, bus.mem_we, bus.mem_re, bus.busy, bus.owner,
                bus.mem_addr, bus.cpu_rdata, bus.dma_rdata};
    endfunction

    task automatic set_in(input logic cr, cw, input logic [7:0] ca, cd,
                          input logic dr, dw, input logic [7:0] da, dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns into cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        step();
        chk("reset_outputs", outv(), 32'h0);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        logic       cr, cw;
        logic [7:0] ca, cd;
        logic       dr, dw;
        logic [7:0] da, dd;
        logic       cak, dak, we, re, bz, own;
        logic [7:0] maddr, crd, drd;
    } vec_t;

    vec_t tbl[$];

    // model state for the random phase
    logic [7:0] shadow [256];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
        reset = 1'b1;
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // rst | cpu req,we,addr,wd | dma req,we,addr,wd | cack dack we re busy own | maddr crd drd
        // CPU write 0x5A to 0x10, then read it back
        tbl.push_back('{1, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,0,0,0,0,0, 8'h00,8'h00,8'h00});
        tbl.push_back('{0, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,0,1,0,1,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 0,0,0,0,1,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,0,0,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,1,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,1,0, 8'h10,8'h00,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,0,0,0, 8'h10,8'h5A,8'h00});
        // tie after reset: CPU reads 0x01, DMA reads 0x02
        tbl.push_back('{1, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,0,0,0,0,0, 8'h00,8'h00,8'h00});
        tbl.push_back('{0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,0,0,1,1,0, 8'h01,8'h00,8'h00});
        tbl.push_back('{0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,0,0,0,1,0, 8'h01,8'h00,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 1,0,0,0,0,0, 8'h01,8'h0A,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, 0,0,0,1,1,1, 8'h02,8'h0A,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,1,1, 8'h02,8'h0A,8'h00});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,1,0,0,0,1, 8'h02,8'h0A,8'h11});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,1, 8'h02,8'h0A,8'h11});
        // boundary: DMA writes 0xA5 to 0xFF, CPU then reads 0xFF
        tbl.push_back('{0, 0,0,8'h00,8'h00, 1,1,8'hFF,8'hA5, 0,0,0,0,0,1, 8'h02,8'h0A,8'h11});
        tbl.push_back('{0, 1,0,8'hFF,8'h00, 1,1,8'hFF,8'hA5, 0,0,1,0,1,1, 8'hFF,8'h0A,8'h11});
        tbl.push_back('{0, 1,0,8'hFF,8'h00, 1,1,8'hFF,8'hA5, 0,0,0,0,1,1, 8'hFF,8'h0A,8'h11});
        tbl.push_back('{0, 1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,1,0,0,0,1, 8'hFF,8'h0A,8'h11});
        tbl.push_back('{0, 1,0,8'hFF,8'h00, 0,0,8'h00,8'h00, 0,0,0,1,1,0, 8'hFF,8'h0A,8'h11});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,1,0, 8'hFF,8'h0A,8'h11});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,0,0,0, 8'hFF,8'hA5,8'h11});
        tbl.push_back('{0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0,0,0, 8'hFF,8'hA5,8'h11});

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            set_in(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                   tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            chk($sformatf("table_row%0d", i), outv(),
                {2'b00, tbl[i].cak, tbl[i].dak, tbl[i].we, tbl[i].re, tbl[i].bz, tbl[i].own,
                 tbl[i].maddr, tbl[i].crd, tbl[i].drd});
            step();
        end

        // single DMA requester held high: acks every 4 cycles starting at 3
        do_reset();
        set_in(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
        for (int c = 0; c < 21; c++) begin
            chk($sformatf("single_dma_ack_c%0d", c), {30'd0, bus.cpu_ack, bus.dma_ack},
                {30'd0, 1'b0, 1'(c % 4 == 3)});
            step();
        end

        // continuous contention: strict alternation starting with CPU
        begin
            int n_acks;
            logic last_ack;
            n_acks = 0;
            last_ack = 1'b1;
            do_reset();
            set_in(1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
            for (int c = 0; c < 30; c++) begin
                chk("contend_one_ack", {31'd0, bus.cpu_ack & bus.dma_ack}, 32'd0);
                chk("contend_we_re", {31'd0, bus.mem_we & bus.mem_re}, 32'd0);
                if (bus.cpu_ack || bus.dma_ack) begin
                    chk("contend_alternate", {31'd0, bus.dma_ack}, {31'd0, ~last_ack});
                    chk("contend_ack_cycle", c, 32'(3 * (n_acks + 1)));
                    last_ack = bus.dma_ack;
                    n_acks++;
                end
                step();
            end
            chk("contend_ack_count", n_acks, 32'd9);
        end

        // reset in ACCESS of a CPU read of 0xFF
        do_reset();
        set_in(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        chk("midreset_access_re", {31'd0, bus.mem_re}, 32'd1);
        reset = 1'b1;
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        chk("midreset_outputs", outv(), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("midreset_no_ack", {31'd0, bus.cpu_ack}, 32'd0);
            step();
        end
        set_in(1, 0, 8'h05, 8'h00, 1, 0, 8'h06, 8'h00);
        step(); step(); step();
        chk("midreset_tie_cpu", {30'd0, bus.cpu_ack, bus.dma_ack}, 32'b10);
        set_in(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (4) step();

        // randomized traffic against a transaction timeline model
        begin
            logic       preq [2];
            logic       pwe  [2];
            logic [7:0] paddr[2];
            logic [7:0] pdat [2];
            bit         granted[2];
            logic [7:0] erd  [2];
            logic [1:0] eack;
            int         next_arb, g, gp, w;
            bit         gv;
            logic       gwe, lastw, eown, ewe, ere, ebz;
            logic [7:0] gaddr, gdata, grexp, emaddr;

            do_reset();
            for (int i = 0; i < 256; i++) shadow[i] = ram[i];
            for (int p = 0; p < 2; p++) begin
                preq[p] = 0; pwe[p] = 0; paddr[p] = 0; pdat[p] = 0;
                granted[p] = 0; erd[p] = 0;
            end
            next_arb = 0; gv = 0; g = 0; gp = 0;
            gwe = 0; gaddr = 0; gdata = 0; grexp = 0;
            lastw = 1; eown = 0; emaddr = 0;

            for (int c = 0; c < 1500; c++) begin
                eack = 2'b00;
                if (gv && c == g + 1) begin eown = 1'(gp); emaddr = gaddr; end
                if (gv && c == g + 3) begin
                    eack[gp] = 1'b1;
                    if (!gwe) erd[gp] = grexp;
                end
                ewe = gv && (c == g + 1) && gwe;
                ere = gv && (c == g + 1) && !gwe;
                ebz = gv && (c == g + 1 || c == g + 2);
                chk($sformatf("random_c%0d", c), outv(),
                    {2'b00, eack[0], eack[1], ewe, ere, ebz, eown, emaddr, erd[0], erd[1]});

                for (int p = 0; p < 2; p++) begin
                    if (eack[p]) begin preq[p] = 0; granted[p] = 0; end
                    if (!preq[p]) begin
                        if ($urandom_range(0, 99) < 40) begin
                            preq[p]  = 1;
                            pwe[p]   = 1'($urandom_range(0, 1));
                            paddr[p] = 8'($urandom_range(0, 7)) + ($urandom_range(0, 1) ? 8'hF8 : 8'h00);
                            pdat[p]  = 8'($urandom);
                        end
                    end else if (!granted[p] && $urandom_range(0, 15) == 0) begin
                        preq[p] = 0;
                    end
                end
                set_in(preq[0], pwe[0], paddr[0], pdat[0], preq[1], pwe[1], paddr[1], pdat[1]);

                if (c >= next_arb) begin
                    logic el0, el1;
                    el0 = preq[0] && !eack[0];
                    el1 = preq[1] && !eack[1];
                    if (el0 || el1) begin
                        w = (el0 && el1) ? int'(!lastw) : int'(el1);
                        gv = 1; g = c; gp = w;
                        gwe = pwe[w]; gaddr = paddr[w]; gdata = pdat[w];
                        if (gwe) shadow[gaddr] = gdata;
                        else     grexp = shadow[gaddr];
                        granted[w] = 1;
                        lastw = 1'(w);
                        next_arb = c + 3;
                    end
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
